// File: rtl/wb_arbiter.sv
// Two-requester register-file write-back arbiter: ALU (A) and load unit (B)
// share one write port with round-robin priority on contention.
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             r_prio;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_cnt;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_conflict;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_sel_addr = a_addr;
    w_sel_data = a_data;
    // Readies also depend on reset so nothing is accepted while it is low.
    if (reset && !hold) begin
      if (a_valid && b_valid) begin
        w_grant_a = (r_prio == PRIO_A);
        w_grant_b = (r_prio == PRIO_B);
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
    if (w_grant_b) begin
      w_sel_addr = b_addr;
      w_sel_data = b_data;
    end
  end

  assign w_conflict = a_valid && b_valid && !hold;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the write-port data registers are reset too, because the
      // register file sees writeAddr/writeData as zero during reset.
      r_prio <= PRIO_A;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_grant_a || w_grant_b) begin
        r_we   <= (w_sel_addr != '0);
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_prio <= w_grant_a ? PRIO_B : PRIO_A;
      end
      if (w_conflict && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign a_ready      = w_grant_a;
  assign b_ready      = w_grant_b;
  assign writeEnable  = r_we;
  assign writeAddr    = r_addr;
  assign writeData    = r_data;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, saturation and
// asynchronous-reset sequences, then randomized traffic against a model.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        hold;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [7:0]  conflict_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_prio;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        hold;
    logic        exp_ar;
    logic        exp_br;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[12];

  wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .hold         (hold),
    .writeEnable  (writeEnable),
    .writeAddr    (writeAddr),
    .writeData    (writeData),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic h);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    hold = h;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " writeEnable"}, {31'd0, writeEnable}, {31'd0, m_we});
    check({tag, " writeAddr"}, {27'd0, writeAddr}, {27'd0, m_addr});
    check({tag, " writeData"}, writeData, m_data);
    check({tag, " conflict_cnt"}, {24'd0, conflict_cnt}, m_cnt);
  endtask

  // Model one cycle from the arbitration rules: returns -1 if nothing is
  // accepted, 0 for A, 1 for B.
  function automatic int model_grant();
    if (hold) return -1;
    if (a_valid && b_valid) return m_prio;
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  task automatic model_edge(input int g);
    m_we = 1'b0;
    if (g >= 0) begin
      m_addr = (g == 0) ? a_addr : b_addr;
      m_data = (g == 0) ? a_data : b_data;
      m_we   = (m_addr != 5'd0);
      m_prio = 1 - g;
    end
    if (a_valid && b_valid && !hold) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd4, 32'h0000FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000FFFF, 8'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678, 8'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h12345678, 8'd0};
    vecs[3]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'hFFFF0000, 8'd1};
    vecs[4]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678, 8'd2};
    vecs[5]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'hFFFF0000, 8'd3};
    vecs[6]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678, 8'd4};
    vecs[7]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 8'd4};
    vecs[8]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 8'd4};
    vecs[9]  = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 8'd4};
    vecs[10] = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 8'd4};
    vecs[11] = '{1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678, 8'd5};

    // Reset state
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    check("reset writeEnable", {31'd0, writeEnable}, 32'd0);
    check("reset writeAddr", {27'd0, writeAddr}, 32'd0);
    check("reset writeData", writeData, 32'd0);
    check("reset conflict_cnt", {24'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd, vecs[i].hold);
      #1;
      check($sformatf("vec%0d a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].exp_ar});
      check($sformatf("vec%0d b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].exp_br});
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d writeEnable", i), {31'd0, writeEnable}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d writeAddr", i), {27'd0, writeAddr}, {27'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d writeData", i), writeData, vecs[i].exp_data);
      check($sformatf("vec%0d conflict_cnt", i), {24'd0, conflict_cnt}, {24'd0, vecs[i].exp_cnt});
    end

    // Saturation: continuous contention for 300 cycles
    m_prio = 0; m_cnt = 5; m_we = 1'b1; m_addr = 5'd9; m_data = 32'h12345678;
    drive(1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0);
    for (int i = 0; i < 300; i++) begin
      model_edge(model_grant());
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat%0d conflict_cnt", i), {24'd0, conflict_cnt}, m_cnt);
    end
    check("sat final", {24'd0, conflict_cnt}, 32'd255);

    // Asynchronous reset while writeEnable is high
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("pre-reset writeEnable", {31'd0, writeEnable}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async writeEnable", {31'd0, writeEnable}, 32'd0);
    check("async writeAddr", {27'd0, writeAddr}, 32'd0);
    check("async writeData", writeData, 32'd0);
    check("async conflict_cnt", {24'd0, conflict_cnt}, 32'd0);
    drive(1'b1, 5'd8, 32'hFFFF0000, 1'b1, 5'd9, 32'h12345678, 1'b0);
    #1;
    check("in-reset a_ready", {31'd0, a_ready}, 32'd0);
    check("in-reset b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("in-reset edge writeEnable", {31'd0, writeEnable}, 32'd0);
    reset = 1'b1;
    #1;
    check("post-reset a_ready", {31'd0, a_ready}, 32'd1);
    check("post-reset b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("post-reset writeEnable", {31'd0, writeEnable}, 32'd1);
    check("post-reset writeAddr", {27'd0, writeAddr}, 32'd8);
    check("post-reset conflict_cnt", {24'd0, conflict_cnt}, 32'd1);

    // Randomized traffic against the model
    m_prio = 1; m_cnt = 1; m_we = 1'b1; m_addr = 5'd8; m_data = 32'hFFFF0000;
    for (int i = 0; i < 400; i++) begin
      int g;
      drive($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 3) == 0);
      #1;
      g = model_grant();
      check($sformatf("rnd%0d a_ready", i), {31'd0, a_ready}, (g == 0) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d b_ready", i), {31'd0, b_ready}, (g == 1) ? 32'd1 : 32'd0);
      model_edge(g);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
